// File: rtl/vram_arbiter.sv
// Arbitrates one async SRAM between video reads, MPU reads and a posted MPU write FIFO.
// Latency: a read returns data 3 cycles after grant; a write completes 4 cycles after grant.
// Backpressure: one pending slot per reader (repeat requests ignored); writes dropped when full, sticky overflow.
module vram_arbiter #(
   parameter int ADDR_WIDTH   = 17,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  videoRequest,
   input  logic [ADDR_WIDTH-1:0] videoAddress,
   output logic [7:0]            videoData,
   output logic                  videoDataReady,
   input  logic [ADDR_WIDTH-1:0] memoryAddress,
   input  logic                  memoryWriteRequest,
   input  logic [7:0]            memoryWriteData,
   output logic                  memoryWriteComplete,
   input  logic                  memoryReadRequest,
   output logic [7:0]            memoryReadData,
   output logic                  memoryReadComplete,
   output logic                  writeFifoFull,
   output logic                  writeOverflow,
   output logic [ADDR_WIDTH-1:0] ramAddress,
   output logic [7:0]            ramDataOut,
   output logic                  ramDataOutEnable,
   input  logic [7:0]            ramDataIn,
   output logic                  ramWriteEnable,
   output logic                  ramOutputEnable
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE, RD_SETUP, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD
   } state_t;

   state_t                  state_q;
   logic                    video_pend_q;
   logic [ADDR_WIDTH-1:0]   video_addr_q;
   logic                    mrd_pend_q;
   logic [ADDR_WIDTH-1:0]   mrd_addr_q;
   logic                    rd_is_video_q;
   logic [SW-1:0]           starve_q;
   logic [SW-1:0]           starve_d;
   logic [PW:0]             wr_ptr_q;
   logic [PW:0]             rd_ptr_q;
   logic                    overflow_q;
   logic [ADDR_WIDTH-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [7:0]              fifo_data_q [FIFO_DEPTH];

   logic [7:0]              video_data_q;
   logic                    video_rdy_q;
   logic [7:0]              mrd_data_q;
   logic                    mrd_done_q;
   logic                    wr_done_q;
   logic [ADDR_WIDTH-1:0]   ram_addr_q;
   logic [7:0]              ram_dout_q;
   logic                    ram_doe_q;
   logic                    ram_we_n_q;
   logic                    ram_oe_n_q;

   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;
   logic mpu_work;
   logic grant_video;
   logic grant_write;
   logic grant_mrd;

   // Pointers carry one wrap bit so equal indices disambiguate full from empty.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push       = memoryWriteRequest && !fifo_full;
   assign pop        = (state_q == WR_HOLD);
   assign mpu_work   = !fifo_empty || mrd_pend_q;

   assign videoData           = video_data_q;
   assign videoDataReady      = video_rdy_q;
   assign memoryReadData      = mrd_data_q;
   assign memoryReadComplete  = mrd_done_q;
   assign memoryWriteComplete = wr_done_q;
   assign writeFifoFull       = fifo_full;
   assign writeOverflow       = overflow_q;
   assign ramAddress          = ram_addr_q;
   assign ramDataOut          = ram_dout_q;
   assign ramDataOutEnable    = ram_doe_q;
   assign ramWriteEnable      = ram_we_n_q;
   assign ramOutputEnable     = ram_oe_n_q;

   // Grant selection in IDLE: video until starved, then queued writes, then MPU read (only once writes drained).
   always_comb begin
      grant_video = 1'b0;
      grant_write = 1'b0;
      grant_mrd   = 1'b0;
      if (state_q == IDLE) begin
         if (video_pend_q && (starve_q < STARVE_MAX)) begin
            grant_video = 1'b1;
         end else if (!fifo_empty) begin
            grant_write = 1'b1;
         end else if (mrd_pend_q) begin
            grant_mrd = 1'b1;
         end else if (video_pend_q) begin
            grant_video = 1'b1;
         end
      end
   end

   // Starvation counter counts video grants only while MPU work is waiting.
   always_comb begin
      starve_d = starve_q;
      if (!mpu_work || grant_write || grant_mrd) begin
         starve_d = '0;
      end else if (grant_video && (starve_q < STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Single-entry request slots; a request while the slot is busy is ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         video_pend_q <= 1'b0;
         video_addr_q <= '0;
         mrd_pend_q   <= 1'b0;
         mrd_addr_q   <= '0;
      end else begin
         if (video_pend_q) begin
            if (grant_video) video_pend_q <= 1'b0;
         end else if (videoRequest) begin
            video_pend_q <= 1'b1;
            video_addr_q <= videoAddress;
         end
         if (mrd_pend_q) begin
            if (grant_mrd) mrd_pend_q <= 1'b0;
         end else if (memoryReadRequest) begin
            mrd_pend_q <= 1'b1;
            mrd_addr_q <= memoryAddress;
         end
      end
   end

   // Write FIFO pointers and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (memoryWriteRequest && fifo_full) overflow_q <= 1'b1;
      end
   end

   // Write FIFO storage; contents are don't-care until pushed.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[PW-1:0]] <= memoryAddress;
         fifo_data_q[wr_ptr_q[PW-1:0]] <= memoryWriteData;
      end
   end

   // SRAM sequencer with registered strobes; every transaction passes back through IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         starve_q      <= '0;
         rd_is_video_q <= 1'b0;
         video_data_q  <= '0;
         video_rdy_q   <= 1'b0;
         mrd_data_q    <= '0;
         mrd_done_q    <= 1'b0;
         wr_done_q     <= 1'b0;
         ram_addr_q    <= '0;
         ram_dout_q    <= '0;
         ram_doe_q     <= 1'b0;
         ram_we_n_q    <= 1'b1;
         ram_oe_n_q    <= 1'b1;
      end else begin
         starve_q    <= starve_d;
         video_rdy_q <= 1'b0;
         mrd_done_q  <= 1'b0;
         wr_done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_video) begin
                  state_q       <= RD_SETUP;
                  ram_addr_q    <= video_addr_q;
                  ram_oe_n_q    <= 1'b0;
                  rd_is_video_q <= 1'b1;
               end else if (grant_write) begin
                  state_q    <= WR_SETUP;
                  ram_addr_q <= fifo_addr_q[rd_ptr_q[PW-1:0]];
                  ram_dout_q <= fifo_data_q[rd_ptr_q[PW-1:0]];
                  ram_doe_q  <= 1'b1;
                  ram_we_n_q <= 1'b1;
               end else if (grant_mrd) begin
                  state_q       <= RD_SETUP;
                  ram_addr_q    <= mrd_addr_q;
                  ram_oe_n_q    <= 1'b0;
                  rd_is_video_q <= 1'b0;
               end
            end
            RD_SETUP: begin
               state_q <= RD_LATCH;
            end
            RD_LATCH: begin
               state_q    <= IDLE;
               ram_oe_n_q <= 1'b1;
               if (rd_is_video_q) begin
                  video_data_q <= ramDataIn;
                  video_rdy_q  <= 1'b1;
               end else begin
                  mrd_data_q <= ramDataIn;
                  mrd_done_q <= 1'b1;
               end
            end
            WR_SETUP: begin
               state_q    <= WR_PULSE;
               ram_we_n_q <= 1'b0;
            end
            WR_PULSE: begin
               state_q    <= WR_HOLD;
               ram_we_n_q <= 1'b1;
            end
            WR_HOLD: begin
               state_q   <= IDLE;
               ram_doe_q <= 1'b0;
               wr_done_q <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               ram_doe_q  <= 1'b0;
               ram_we_n_q <= 1'b1;
               ram_oe_n_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table vectors, directed corner sequences, random traffic vs. a transaction-level model.
// Latency is measured in clock edges from the request edge to the response pulse.
// The SRAM is modelled as a byte array written on WE low and read combinationally while OE is low.
module tb_vram_arbiter;

   localparam int AW    = 17;
   localparam int DEPTH = 4;
   localparam int SLIM  = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          videoRequest;
   logic [AW-1:0] videoAddress;
   logic [7:0]    videoData;
   logic          videoDataReady;
   logic [AW-1:0] memoryAddress;
   logic          memoryWriteRequest;
   logic [7:0]    memoryWriteData;
   logic          memoryWriteComplete;
   logic          memoryReadRequest;
   logic [7:0]    memoryReadData;
   logic          memoryReadComplete;
   logic          writeFifoFull;
   logic          writeOverflow;
   logic [AW-1:0] ramAddress;
   logic [7:0]    ramDataOut;
   logic          ramDataOutEnable;
   logic [7:0]    ramDataIn;
   logic          ramWriteEnable;
   logic          ramOutputEnable;

   always #5 clock = ~clock;

   vram_arbiter #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
      .clock(clock), .reset(reset),
      .videoRequest(videoRequest), .videoAddress(videoAddress),
      .videoData(videoData), .videoDataReady(videoDataReady),
      .memoryAddress(memoryAddress), .memoryWriteRequest(memoryWriteRequest),
      .memoryWriteData(memoryWriteData), .memoryWriteComplete(memoryWriteComplete),
      .memoryReadRequest(memoryReadRequest), .memoryReadData(memoryReadData),
      .memoryReadComplete(memoryReadComplete), .writeFifoFull(writeFifoFull),
      .writeOverflow(writeOverflow), .ramAddress(ramAddress), .ramDataOut(ramDataOut),
      .ramDataOutEnable(ramDataOutEnable), .ramDataIn(ramDataIn),
      .ramWriteEnable(ramWriteEnable), .ramOutputEnable(ramOutputEnable)
   );

   // SRAM model
   logic [7:0] sram   [0:(1<<AW)-1];
   logic [7:0] shadow [0:(1<<AW)-1];
   assign ramDataIn = (!ramOutputEnable) ? sram[ramAddress] : 8'h00;
   always @(posedge clock) if (!ramWriteEnable && ramDataOutEnable) sram[ramAddress] = ramDataOut;

   function automatic logic [7:0] pat(input int a);
      int t;
      t = (a ^ (a >> 8)) + 8'h3C;
      return t[7:0];
   endfunction

   int n_checks = 0, n_fail = 0, viol = 0;
   int wc_cnt = 0, vr_cnt = 0, rc_cnt = 0;

   // Bus-protocol monitor: strobe overlap and data-enable outside write cycles
   always @(negedge clock) begin
      if (!ramWriteEnable && !ramOutputEnable) viol++;
      if (ramDataOutEnable && !ramOutputEnable) viol++;
      if (!ramWriteEnable && !ramDataOutEnable) viol++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clock);
      if (memoryWriteComplete) wc_cnt++;
      if (videoDataReady) vr_cnt++;
      if (memoryReadComplete) rc_cnt++;
   endtask

   task automatic drop_reqs();
      videoRequest = 1'b0;
      memoryWriteRequest = 1'b0;
      memoryReadRequest = 1'b0;
   endtask

   task automatic reset_dut();
      drop_reqs();
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      cyc();
   endtask

   // op 0 = MPU write, 1 = video read, 2 = MPU read; strobes counts cycles with WE (write) or OE (read) low
   task automatic run_op(input int op, input logic [AW-1:0] a, input logic [7:0] wd,
                         output logic [7:0] d, output int lat, output int strobes);
      bit done;
      done = 1'b0; lat = -1; strobes = 0; d = '0;
      if (op == 0) begin memoryWriteRequest = 1'b1; memoryAddress = a; memoryWriteData = wd; end
      else if (op == 1) begin videoRequest = 1'b1; videoAddress = a; end
      else begin memoryReadRequest = 1'b1; memoryAddress = a; end
      for (int c = 1; c <= 20 && !done; c++) begin
         cyc();
         drop_reqs();
         if ((op == 0) ? !ramWriteEnable : !ramOutputEnable) strobes++;
         if (op == 0 && memoryWriteComplete) begin done = 1'b1; lat = c - 1; d = sram[a]; end
         if (op == 1 && videoDataReady) begin done = 1'b1; lat = c - 1; d = videoData; end
         if (op == 2 && memoryReadComplete) begin done = 1'b1; lat = c - 1; d = memoryReadData; end
      end
   endtask

   typedef struct {
      int         op;
      logic [16:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_data;
      int         exp_lat;
      int         exp_strobe;
   } vec_t;

   vec_t vecs[8];

   // Random-phase model state
   logic [7:0] exp_vq[$];
   logic [7:0] exp_mq[$];
   bit         vid_out, mrd_out, exp_ovf;
   int         occ;

   task automatic observe();
      if (videoDataReady) begin
         check("rnd_video_expected", exp_vq.size() != 0, 1);
         if (exp_vq.size() != 0) check("rnd_video_data", videoData, exp_vq.pop_front());
         vid_out = 1'b0;
      end
      if (memoryReadComplete) begin
         check("rnd_mread_expected", exp_mq.size() != 0, 1);
         if (exp_mq.size() != 0) check("rnd_mread_data", memoryReadData, exp_mq.pop_front());
         mrd_out = 1'b0;
      end
      if (memoryWriteComplete) begin
         check("rnd_wcomplete_outstanding", occ > 0, 1);
         occ--;
      end
      check("rnd_fifo_full", writeFifoFull, occ == DEPTH);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   logic [7:0]    d, d2;
   int            lat, str, wc0, vr0, got, mism, nv, nm;
   logic [AW-1:0] va, ma;
   logic [7:0]    wd;

   initial begin
      for (int i = 0; i < (1 << AW); i++) sram[i] = pat(i);
      sram[17'h00100] = 8'h5A;

      vecs[0] = '{0, 17'h00010, 8'h11, 8'h11, 4, 1};
      vecs[1] = '{1, 17'h00010, 8'h00, 8'h11, 3, 2};
      vecs[2] = '{2, 17'h00010, 8'h00, 8'h11, 3, 2};
      vecs[3] = '{0, 17'h1FFFF, 8'hFF, 8'hFF, 4, 1};
      vecs[4] = '{2, 17'h1FFFF, 8'h00, 8'hFF, 3, 2};
      vecs[5] = '{1, 17'h00100, 8'h00, 8'h5A, 3, 2};
      vecs[6] = '{0, 17'h00000, 8'h00, 8'h00, 4, 1};
      vecs[7] = '{1, 17'h00000, 8'h00, 8'h00, 3, 2};

      videoAddress = '0; memoryAddress = '0; memoryWriteData = '0;
      reset_dut();

      // Reset state
      check("rst_we_n", ramWriteEnable, 1);
      check("rst_oe_n", ramOutputEnable, 1);
      check("rst_doe", ramDataOutEnable, 0);
      check("rst_addr", ramAddress, 0);
      check("rst_dout", ramDataOut, 0);
      check("rst_rdata", {videoData, memoryReadData}, 0);
      check("rst_pulses", {videoDataReady, memoryReadComplete, memoryWriteComplete}, 0);
      check("rst_flags", {writeFifoFull, writeOverflow}, 0);

      // Single transactions from idle
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, d, lat, str);
         check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_strobe_cycles", i), str, vecs[i].exp_strobe);
         repeat (2) cyc();
      end

      // Five back-to-back pushes: fourth fills the FIFO, fifth is dropped
      wc0 = wc_cnt;
      for (int i = 0; i < 5; i++) begin
         memoryWriteRequest = 1'b1;
         memoryAddress = AW'(i);
         memoryWriteData = 8'hC0 + 8'(i);
         cyc();
         if (i == 3) check("fill_full_after_4", writeFifoFull, 1);
      end
      drop_reqs();
      check("fill_overflow", writeOverflow, 1);
      for (int c = 0; c < 40 && (wc_cnt - wc0) < 4; c++) cyc();
      repeat (10) cyc();
      check("fill_completions", wc_cnt - wc0, 4);
      for (int i = 0; i < 4; i++) check($sformatf("fill_sram_%0d", i), sram[i], 8'hC0 + 8'(i));
      check("fill_dropped_untouched", sram[4], pat(4));
      check("fill_overflow_sticky", writeOverflow, 1);
      reset_dut();
      check("overflow_cleared", writeOverflow, 0);

      // Read-after-write ordering
      wc0 = wc_cnt;
      memoryWriteRequest = 1'b1; memoryAddress = 17'h1F000; memoryWriteData = 8'hA5;
      cyc();
      drop_reqs();
      memoryReadRequest = 1'b1; memoryAddress = 17'h1F000;
      cyc();
      drop_reqs();
      got = -1;
      for (int c = 0; c < 30 && got < 0; c++) begin
         cyc();
         if (memoryReadComplete) begin got = wc_cnt - wc0; d = memoryReadData; end
      end
      check("raw_write_before_read", got, 1);
      check("raw_read_data", d, 8'hA5);
      repeat (2) cyc();

      // Repeat video request while pending is ignored
      vr0 = vr_cnt;
      videoRequest = 1'b1; videoAddress = 17'h08010;
      cyc();
      videoAddress = 17'h08020;
      cyc();
      drop_reqs();
      d = '0;
      for (int c = 0; c < 12; c++) begin
         cyc();
         if (videoDataReady) d = videoData;
      end
      check("pend_ignore_count", vr_cnt - vr0, 1);
      check("pend_ignore_data", d, pat(17'h08010));

      // Simultaneous video and MPU read are both served
      vr0 = vr_cnt; got = rc_cnt;
      videoRequest = 1'b1; videoAddress = 17'h08030;
      memoryReadRequest = 1'b1; memoryAddress = 17'h08040;
      cyc();
      drop_reqs();
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (videoDataReady) d = videoData;
         if (memoryReadComplete) d2 = memoryReadData;
      end
      check("dual_counts", {vr_cnt - vr0, rc_cnt - got}, {32'd1, 32'd1});
      check("dual_video_data", d, pat(17'h08030));
      check("dual_mread_data", d2, pat(17'h08040));

      // Continuous video with one pending write: write after STARVE_LIMIT video grants
      vr0 = vr_cnt; wc0 = wc_cnt; got = -1;
      for (int c = 0; c < 80 && got < 0; c++) begin
         videoRequest = 1'b1; videoAddress = 17'h08100;
         memoryWriteRequest = (c == 0); memoryAddress = 17'h00060; memoryWriteData = 8'h3C;
         cyc();
         if (wc_cnt != wc0) got = vr_cnt - vr0;
      end
      drop_reqs();
      repeat (10) cyc();
      check("starve_video_grants", got, SLIM);
      check("starve_write_data", sram[17'h00060], 8'h3C);

      // Reset during WR_PULSE abandons the write
      reset_dut();
      wc0 = wc_cnt;
      memoryWriteRequest = 1'b1; memoryAddress = 17'h00040; memoryWriteData = 8'h77;
      cyc();
      drop_reqs();
      repeat (2) cyc();
      check("midwr_we_low_before_reset", ramWriteEnable, 0);
      reset = 1'b1;
      cyc();
      check("midwr_we_released", ramWriteEnable, 1);
      check("midwr_doe_released", ramDataOutEnable, 0);
      reset = 1'b0;
      cyc();
      run_op(2, 17'h00050, 8'h00, d, lat, str);
      check("midwr_fifo_empty_read_latency", lat, 3);
      check("midwr_read_data", d, pat(17'h00050));
      repeat (4) cyc();
      check("midwr_no_completion", wc_cnt - wc0, 0);

      // Random traffic against transaction-level model
      reset_dut();
      for (int i = 0; i < (1 << AW); i++) shadow[i] = sram[i];
      vid_out = 1'b0; mrd_out = 1'b0; exp_ovf = 1'b0; occ = 0;
      for (int k = 0; k < 10000; k++) begin
         drop_reqs();
         if (!vid_out && $urandom_range(0, 3) == 0) begin
            va = 17'h08000 + AW'($urandom_range(0, 32767));
            videoRequest = 1'b1; videoAddress = va;
            exp_vq.push_back(pat(int'(va)));
            vid_out = 1'b1;
         end
         if (!mrd_out && $urandom_range(0, 5) == 0) begin
            ma = 17'h10000 + AW'($urandom_range(0, 63));
            memoryReadRequest = 1'b1; memoryAddress = ma;
            exp_mq.push_back(shadow[ma]);
            mrd_out = 1'b1;
         end else if (!mrd_out && $urandom_range(0, 2) == 0) begin
            ma = 17'h10000 + AW'($urandom_range(0, 63));
            wd = 8'($urandom);
            memoryWriteRequest = 1'b1; memoryAddress = ma; memoryWriteData = wd;
            if (occ < DEPTH) begin occ++; shadow[ma] = wd; end
            else exp_ovf = 1'b1;
         end
         cyc();
         observe();
      end
      drop_reqs();
      for (int k = 0; k < 300 && (vid_out || mrd_out || occ != 0); k++) begin
         cyc();
         observe();
      end
      nv = exp_vq.size(); nm = exp_mq.size();
      check("rnd_drained", {vid_out, mrd_out, 30'(occ)}, 0);
      check("rnd_queues_empty", nv + nm, 0);
      check("rnd_overflow", writeOverflow, exp_ovf);
      mism = 0;
      for (int a = 17'h10000; a < 17'h10040; a++) if (sram[a] !== shadow[a]) mism++;
      check("rnd_final_memory_mismatches", mism, 0);
      check("protocol_violations", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 17, SRAM address width; FIFO_DEPTH, default 4, MPU write FIFO entries (power of 2); STARVE_LIMIT, default 8, maximum consecutive video grants while MPU work is pending.
REQ-002 Ports SHALL be (name direction width meaning):
- clock in 1: single clock; all logic rising-edge.
- reset in 1: synchronous, active-high.
- videoRequest in 1: one-cycle pulse requesting a read.
- videoAddress in ADDR_WIDTH: read address, sampled with videoRequest.
- videoData out 8: returned byte.
- videoDataReady out 1: one-cycle pulse, videoData valid.
- memoryAddress in ADDR_WIDTH: MPU address, sampled with either request.
- memoryWriteRequest in 1: one-cycle pulse, push write.
- memoryWriteData in 8: write byte, sampled with memoryWriteRequest.
- memoryWriteComplete out 1: one-cycle pulse per SRAM write finished, in order.
- memoryReadRequest in 1: one-cycle pulse, MPU read.
- memoryReadData out 8: returned byte.
- memoryReadComplete out 1: one-cycle pulse, memoryReadData valid.
- writeFifoFull out 1: FIFO holds FIFO_DEPTH entries.
- writeOverflow out 1: sticky, push attempted while full.
- ramAddress out ADDR_WIDTH: SRAM address.
- ramDataOut out 8: SRAM write data.
- ramDataOutEnable out 1: top-level tristate enable for ramData.
- ramDataIn in 8: SRAM read data.
- ramWriteEnable out 1: active-low SRAM WE.
- ramOutputEnable out 1: active-low SRAM OE.

Function
REQ-003 Video and MPU read requests SHALL each be latched as one pending slot; a request while its slot is pending SHALL be ignored.
REQ-004 memoryWriteRequest while not full SHALL push {address, data} into the FIFO; while full it SHALL be dropped and set writeOverflow.
REQ-005 States SHALL be IDLE, RD_SETUP, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-006 In IDLE, grant priority SHALL be: video if pending and starveCount < STARVE_LIMIT; else FIFO head if non-empty; else MPU read if pending; else video if pending; else stay IDLE.
REQ-007 An MPU read SHALL NOT be granted while the FIFO is non-empty (read-after-write ordering).
REQ-008 Read: RD_SETUP drives ramAddress, ramOutputEnable=0; RD_LATCH keeps both and captures ramDataIn at its end; the corresponding ready/complete pulse SHALL occur the cycle after RD_LATCH, with the data register updated.
REQ-009 Write: WR_SETUP drives address, ramDataOut, ramDataOutEnable=1, WE=1; WR_PULSE WE=0; WR_HOLD WE=1, data still driven; FIFO pop and memoryWriteComplete pulse SHALL occur the cycle after WR_HOLD.
REQ-010 ramWriteEnable and ramOutputEnable SHALL never be low in the same cycle; ramDataOutEnable SHALL be 1 only in WR_* states.
REQ-011 Each transaction SHALL return to IDLE for one cycle before the next grant; video read turnaround is therefore 3 cycles.
REQ-012 starveCount SHALL increment (saturating at STARVE_LIMIT) on each video grant while MPU work is pending, and clear on any MPU grant or when no MPU work is pending.
REQ-013 Simultaneous push and pop SHALL keep occupancy unchanged; simultaneous video and MPU requests SHALL both be captured.
REQ-014 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH; full/empty derived from MSB comparison.

Reset
REQ-015 On reset: state IDLE; FIFO empty; pending slots, starveCount, writeOverflow cleared; ramWriteEnable=1, ramOutputEnable=1, ramDataOutEnable=0, ramAddress=0, ramDataOut=0; videoData=0, memoryReadData=0; all pulses 0.
REQ-016 Reset asserted mid-write SHALL release WE at the next edge; the write is abandoned with no memoryWriteComplete.

Verification
REQ-017 Video read 0x00100, SRAM model returns 0x5A -> OE low 2 cycles, videoDataReady with videoData=0x5A exactly 3 cycles after request.
REQ-018 Five write pushes (addrs 0x0..0x4) back-to-back, no video -> writeFifoFull after 4th, 5th dropped, writeOverflow=1, four completes in order, SRAM holds 4 bytes.
REQ-019 Write 0xA5 to 0x1F000 then immediate read of 0x1F000 -> read granted after write completes, memoryReadData=0xA5.
REQ-020 Continuous video requests plus one pending write -> write granted after at most 8 video grants.
REQ-021 Reset in WR_PULSE -> ramWriteEnable=1 next cycle, no completion, FIFO empty.
REQ-022 Random traffic 10k cycles -> assertion: WE and OE never simultaneously low; data enable only in WR_* states.
